imem_dmem_arbiter: RTL and testbench

//  Shares the single off-chip memory port between I-cache and D-cache refill/write-back traffic.

---
 rtl/imem_dmem_arbiter_if.sv | 38 +++
 rtl/imem_dmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the I-cache, D-cache, the shared memory port and imem_dmem_arbiter.
// The slave modport is the arbiter's view; master is the view of the caches plus memory.
interface imem_dmem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    // Handshake: each requester raises *_read/*_write with a stable address/data and holds
    // them until its *_ready pulses for exactly one cycle; the memory answers a strobe
    // with a one-cycle mem_ready, and *_rdata is only meaningful in that ready cycle.
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache and D-cache, with a one-cycle
// lock after a D write-back. Optional perf counters are built when ARB_PERF_CNT_EN is defined.
module imem_dmem_arbiter
`ifdef ARB_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic                clk,
    input  logic                rst_n,
    imem_dmem_arbiter_if.slave  bus,
    output logic [1:0]          dbg_state
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    perf_i_cnt,
    output logic [CNT_W-1:0]    perf_d_cnt,
    output logic [CNT_W-1:0]    perf_conf
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GNT_I  = 2'd1;
    localparam logic [1:0] S_GNT_D  = 2'd2;
    localparam logic [1:0] S_LOCK_D = 2'd3;

    logic [1:0] state_q, state_d;
    logic       last_d_q, last_d_d;
    logic       i_req, d_req;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            S_IDLE: begin
                if (i_req && d_req) begin
                    state_d = last_d_q ? S_GNT_I : S_GNT_D;
                end else if (i_req) begin
                    state_d = S_GNT_I;
                end else if (d_req) begin
                    state_d = S_GNT_D;
                end
            end
            S_GNT_I: begin
                if (bus.mem_ready) begin
                    state_d  = S_IDLE;
                    last_d_d = 1'b0;
                end
            end
            S_GNT_D: begin
                // A completed write-back keeps the port so the refill read cannot be overtaken.
                if (bus.mem_ready) begin
                    if (bus.d_write) begin
                        state_d = S_LOCK_D;
                    end else begin
                        state_d  = S_IDLE;
                        last_d_d = 1'b1;
                    end
                end
            end
            S_LOCK_D: begin
                if (bus.d_read) begin
                    state_d = S_GNT_D;
                end else begin
                    state_d  = S_IDLE;
                    last_d_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    // Outputs decode the registered grant only; IDLE and LOCK_D are dead cycles on the port.
    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = bus.i_addr;
        bus.mem_wdata = bus.d_wdata;
        bus.i_ready   = 1'b0;
        bus.d_ready   = 1'b0;
        case (state_q)
            S_GNT_I: begin
                bus.mem_read = bus.i_read;
                bus.i_ready  = bus.mem_ready;
            end
            S_GNT_D: begin
                bus.mem_read  = bus.d_read;
                bus.mem_write = bus.d_write;
                bus.mem_addr  = bus.d_addr;
                bus.d_ready   = bus.mem_ready;
            end
            default: begin
                bus.mem_read = 1'b0;
            end
        endcase
    end

    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
    assign dbg_state   = state_q;

`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] perf_i_q, perf_i_d;
    logic [CNT_W-1:0] perf_d_q, perf_d_d;
    logic [CNT_W-1:0] perf_conf_q, perf_conf_d;

    always_comb begin
        perf_i_d    = perf_i_q;
        perf_d_d    = perf_d_q;
        perf_conf_d = perf_conf_q;
        if (state_q == S_IDLE && state_d == S_GNT_I) begin
            perf_i_d = perf_i_q + CNT_W'(1);
        end
        // The refill grant out of LOCK_D counts as a fresh D grant.
        if ((state_q == S_IDLE || state_q == S_LOCK_D) && state_d == S_GNT_D) begin
            perf_d_d = perf_d_q + CNT_W'(1);
        end
        if (state_q == S_IDLE && i_req && d_req) begin
            perf_conf_d = perf_conf_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_i_q    <= '0;
            perf_d_q    <= '0;
            perf_conf_q <= '0;
        end else begin
            perf_i_q    <= perf_i_d;
            perf_d_q    <= perf_d_d;
            perf_conf_q <= perf_conf_d;
        end
    end

    assign perf_i_cnt = perf_i_q;
    assign perf_d_cnt = perf_d_q;
    assign perf_conf  = perf_conf_q;
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: cache agents plus a memory model, checked each cycle against a
// transaction-level model of port ownership, then directed scenarios and a random mix.
module tb_imem_dmem_arbiter;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    imem_dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] perf_i_cnt, perf_d_cnt, perf_conf;
    imem_dmem_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .dbg_state(dbg_state),
        .perf_i_cnt(perf_i_cnt), .perf_d_cnt(perf_d_cnt), .perf_conf(perf_conf)
    );
`else
    imem_dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .dbg_state(dbg_state)
    );
`endif

    typedef struct {
        bit                wr;
        bit                refill;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] raddr;
    } d_op_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // stimulus controls
    bit rst_req = 1'b0;
    int lat_fixed = -1;
    bit stray_en = 1'b0;
    bit force_ready = 1'b0;
    bit rand_gaps = 1'b0;

    // cache agents
    logic [ADDR_W-1:0] i_todo[$];
    logic [ADDR_W-1:0] i_cur = '0;
    bit i_active = 1'b0;
    int i_gap = 0;
    d_op_t d_todo[$];
    d_op_t d_cur;
    int d_phase = 0;  // 0 idle, 1 first access, 2 refill after write-back
    int d_gap = 0;

    // memory contents
    logic [DATA_W-1:0] mem_arr [logic [ADDR_W-1:0]];

    // reference model: who owns the port, and the post-write-back hold cycle
    int m_owner = 0;  // 0 nobody, 1 I-cache, 2 D-cache
    bit m_wb_hold = 1'b0;
    bit m_d_last = 1'b0;
    int m_lat = 0;
    int m_lat_cnt = 0;
    int m_perf_i = 0;
    int m_perf_d = 0;
    int m_perf_conf = 0;

    // DUT-side observations for directed checks
    logic [15:0] order_bits;
    int order_n, first_mr_cyc, ir_cyc, dr_cyc, ir_pulses, dr_pulses;
    logic [ADDR_W-1:0] first_mr_addr;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {4{4'hA, a}};
    endfunction

    function automatic bit busy();
        return (i_todo.size() > 0) || i_active || (d_todo.size() > 0) || (d_phase != 0) ||
               (m_owner != 0) || m_wb_hold;
    endfunction

    task automatic clear_obs();
        order_bits = '0;
        order_n = 0;
        first_mr_cyc = -1;
        ir_cyc = -1;
        dr_cyc = -1;
        ir_pulses = 0;
        dr_pulses = 0;
        first_mr_addr = '0;
    endtask

    task automatic start_grant(input int who);
        m_owner = who;
        m_lat_cnt = 0;
        m_lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
        if (who == 1) m_perf_i++;
        if (who == 2) m_perf_d++;
    endtask

    task automatic tick();
        logic exp_mr, exp_mw, exp_ir, exp_dr, both, d_req;
        logic [ADDR_W-1:0] acc_addr;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = rst_req;
        if (!i_active && i_todo.size() > 0) begin
            if (i_gap > 0) i_gap--;
            else begin
                i_cur = i_todo.pop_front();
                i_active = 1'b1;
            end
        end
        bus.i_read = i_active;
        bus.i_addr = i_active ? i_cur : ADDR_W'($urandom);
        if (d_phase == 0 && d_todo.size() > 0) begin
            if (d_gap > 0) d_gap--;
            else begin
                d_cur = d_todo.pop_front();
                d_phase = 1;
            end
        end
        bus.d_read  = (d_phase == 1 && !d_cur.wr) || d_phase == 2;
        bus.d_write = (d_phase == 1 && d_cur.wr);
        bus.d_addr  = (d_phase == 2) ? d_cur.raddr : d_cur.addr;
        bus.d_wdata = d_cur.wdata;

        // memory: answers the port owner after its latency; stray pulses while nobody owns it
        acc_addr = (m_owner == 2) ? bus.d_addr : bus.i_addr;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (rst_n && m_owner != 0 && m_lat_cnt >= m_lat) begin
            bus.mem_ready = 1'b1;
            if (!(m_owner == 2 && bus.d_write)) bus.mem_rdata = mem_val(acc_addr);
        end else if (rst_n && m_owner == 0 && (force_ready || (stray_en && $urandom_range(0, 7) == 0))) begin
            bus.mem_ready = 1'b1;
        end
        force_ready = 1'b0;

        exp_mr = 1'b0; exp_mw = 1'b0; exp_ir = 1'b0; exp_dr = 1'b0;
        if (m_owner == 1) begin
            exp_mr = bus.i_read;
            exp_ir = bus.mem_ready;
        end else if (m_owner == 2) begin
            exp_mr = bus.d_read;
            exp_mw = bus.d_write;
            exp_dr = bus.mem_ready;
        end

        @(negedge clk);
        check("mem_read", DATA_W'(bus.mem_read), DATA_W'(exp_mr));
        check("mem_write", DATA_W'(bus.mem_write), DATA_W'(exp_mw));
        check("i_ready", DATA_W'(bus.i_ready), DATA_W'(exp_ir));
        check("d_ready", DATA_W'(bus.d_ready), DATA_W'(exp_dr));
        if (exp_mr || exp_mw) check("mem_addr", DATA_W'(bus.mem_addr), DATA_W'(acc_addr));
        if (exp_mw) check("mem_wdata", bus.mem_wdata, d_cur.wdata);
        if (exp_ir) check("i_rdata", bus.i_rdata, mem_val(i_cur));
        if (exp_dr && !bus.d_write) check("d_rdata", bus.d_rdata, mem_val(bus.d_addr));
`ifdef ARB_PERF_CNT_EN
        check("perf_i_cnt", DATA_W'(perf_i_cnt), DATA_W'(m_perf_i));
        check("perf_d_cnt", DATA_W'(perf_d_cnt), DATA_W'(m_perf_d));
        check("perf_conf", DATA_W'(perf_conf), DATA_W'(m_perf_conf));
`endif

        if (bus.mem_read === 1'b1 && first_mr_cyc < 0) begin
            first_mr_cyc = cyc;
            first_mr_addr = bus.mem_addr;
        end
        if (bus.i_ready === 1'b1) begin
            ir_pulses++;
            if (ir_cyc < 0) ir_cyc = cyc;
            order_bits = {order_bits[14:0], 1'b0};
            order_n++;
        end
        if (bus.d_ready === 1'b1) begin
            dr_pulses++;
            if (dr_cyc < 0) dr_cyc = cyc;
            order_bits = {order_bits[14:0], 1'b1};
            order_n++;
        end

        // advance the model and the agents to the next cycle
        d_req = bus.d_read || bus.d_write;
        both = bus.i_read && d_req;
        if (!rst_n) begin
            m_owner = 0; m_wb_hold = 1'b0; m_d_last = 1'b0;
            m_perf_i = 0; m_perf_d = 0; m_perf_conf = 0;
            i_active = 1'b0; d_phase = 0;
            i_todo.delete(); d_todo.delete();
        end else begin
            if (m_wb_hold) begin
                m_wb_hold = 1'b0;
                if (bus.d_read) start_grant(2);
                else m_d_last = 1'b1;
            end else if (m_owner == 0) begin
                if (both) begin
                    m_perf_conf++;
                    start_grant(m_d_last ? 1 : 2);
                end else if (bus.i_read) start_grant(1);
                else if (d_req) start_grant(2);
            end else if (bus.mem_ready) begin
                if (m_owner == 1) m_d_last = 1'b0;
                else if (bus.d_write) m_wb_hold = 1'b1;
                else m_d_last = 1'b1;
                m_owner = 0;
            end else begin
                m_lat_cnt++;
            end
            if (exp_ir) begin
                i_active = 1'b0;
                i_gap = rand_gaps ? int'($urandom_range(0, 2)) : 0;
            end
            if (exp_dr) begin
                if (d_phase == 1 && d_cur.wr) begin
                    mem_arr[d_cur.addr] = d_cur.wdata;
                    d_phase = d_cur.refill ? 2 : 0;
                end else begin
                    d_phase = 0;
                end
                d_gap = rand_gaps ? int'($urandom_range(0, 2)) : 0;
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", DATA_W'(busy()), '0);
        tick();
        tick();
    endtask

    task automatic reset_cycles(input int n);
        rst_req = 1'b0;
        for (int k = 0; k < n; k++) tick();
        rst_req = 1'b1;
    endtask

    function automatic d_op_t mk_op(input bit wr, input bit refill, input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] ra);
        d_op_t op;
        op.wr = wr;
        op.refill = refill;
        op.addr = a;
        op.raddr = ra;
        op.wdata = {$urandom, $urandom, $urandom, $urandom};
        return op;
    endfunction

    initial begin
        int req_cyc;
        bus.i_read = 1'b0; bus.i_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_ready = 1'b0;
        d_cur = mk_op(1'b0, 1'b0, '0, '0);
        clear_obs();

        // reset state: strobes and readies low while held in reset
        reset_cycles(3);
        tick();
        check("reset_state", DATA_W'(dbg_state), '0);

        // lone I miss: grant one cycle after the request, ready after four granted cycles
        clear_obs();
        lat_fixed = 4;
        i_todo.push_back(28'h0000040);
        req_cyc = cyc + 1;
        run_until_idle(50);
        check("lone_i_first_read_cyc", DATA_W'(first_mr_cyc), DATA_W'(req_cyc + 1));
        check("lone_i_addr", DATA_W'(first_mr_addr), DATA_W'(28'h40));
        check("lone_i_ready_cyc", DATA_W'(ir_cyc), DATA_W'(req_cyc + 5));
        check("lone_i_ready_pulses", DATA_W'(ir_pulses), DATA_W'(1));

        // contention right after reset: D first, I after the dead cycle
        reset_cycles(2);
        clear_obs();
        lat_fixed = 0;
        i_todo.push_back(28'h0000123);
        d_todo.push_back(mk_op(1'b0, 1'b0, 28'h0000456, '0));
        req_cyc = cyc + 1;
        run_until_idle(50);
        check("contend_order", DATA_W'(order_bits), DATA_W'(16'b10));
        check("contend_d_cyc", DATA_W'(dr_cyc), DATA_W'(req_cyc + 1));
        check("contend_i_cyc", DATA_W'(ir_cyc), DATA_W'(req_cyc + 3));
`ifdef ARB_PERF_CNT_EN
        check("contend_perf_conf", DATA_W'(perf_conf), DATA_W'(1));
`endif

        // write-back lock: refill read is served before the pending I request
        reset_cycles(2);
        clear_obs();
        lat_fixed = -1;
        i_todo.push_back(28'h0000300);
        d_todo.push_back(mk_op(1'b1, 1'b1, 28'h0000100, 28'h0000200));
        run_until_idle(80);
        check("wb_order", DATA_W'(order_bits), DATA_W'(16'b110));
        check("wb_order_n", DATA_W'(order_n), DATA_W'(3));
`ifdef ARB_PERF_CNT_EN
        check("wb_perf_d", DATA_W'(perf_d_cnt), DATA_W'(2));
`endif

        // fairness: both keep requesting, grants alternate D,I,D,I
        reset_cycles(2);
        clear_obs();
        i_todo.push_back(28'h0000010);
        i_todo.push_back(28'h0000011);
        d_todo.push_back(mk_op(1'b0, 1'b0, 28'h0000020, '0));
        d_todo.push_back(mk_op(1'b0, 1'b0, 28'h0000021, '0));
        run_until_idle(100);
        check("fair_order", DATA_W'(order_bits), DATA_W'(16'b1010));
        check("fair_order_n", DATA_W'(order_n), DATA_W'(4));
`ifdef ARB_PERF_CNT_EN
        check("fair_perf_i", DATA_W'(perf_i_cnt), DATA_W'(2));
        check("fair_perf_d", DATA_W'(perf_d_cnt), DATA_W'(2));
`endif

        // reset while D is granted and the memory has not answered; a late ready is ignored
        reset_cycles(2);
        clear_obs();
        lat_fixed = 10;
        d_todo.push_back(mk_op(1'b0, 1'b0, 28'h0000055, '0));
        tick(); tick(); tick();
        check("rst_d_granted", DATA_W'(bus.mem_read), DATA_W'(1));
        rst_req = 1'b0;
        tick();
        rst_req = 1'b1;
        force_ready = 1'b1;
        tick();
        check("rst_d_idle_read", DATA_W'(bus.mem_read), DATA_W'(0));
        tick(); tick();
        check("rst_d_no_ready", DATA_W'(dr_pulses), DATA_W'(0));

        // reset while I is granted: i_ready never pulses
        clear_obs();
        i_todo.push_back(28'h0000077);
        tick(); tick(); tick();
        check("rst_i_granted", DATA_W'(bus.mem_read), DATA_W'(1));
        rst_req = 1'b0;
        tick();
        rst_req = 1'b1;
        tick();
        check("rst_i_idle_read", DATA_W'(bus.mem_read), DATA_W'(0));
        tick(); tick();
        check("rst_i_no_ready", DATA_W'(ir_pulses), DATA_W'(0));

        // random mix with stray memory readies and random gaps/latencies
        reset_cycles(2);
        lat_fixed = -1;
        stray_en = 1'b1;
        rand_gaps = 1'b1;
        for (int k = 0; k < 40; k++) begin
            i_todo.push_back(ADDR_W'($urandom_range(0, 15)));
            d_todo.push_back(mk_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                   ADDR_W'($urandom_range(0, 15)), ADDR_W'($urandom_range(0, 15))));
        end
        run_until_idle(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
